// File: rtl/eth_phy_10g_pkg.sv
// -----------------------------------------------------------------------------
// eth_phy_10g_pkg
// Shared types and default constants for the eth_phy_10g receive link
// controller.
//   STATE_W        : width of the link state encoding
//   link_state_e   : link sequencer states (encoding visible on link_state)
//   *_DEF          : default timing / retry parameters
// -----------------------------------------------------------------------------
package eth_phy_10g_pkg;

   localparam int unsigned STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_PHY_RST     = 3'd0,
      ST_WAIT_LOCK   = 3'd1,
      ST_WAIT_STATUS = 3'd2,
      ST_LINK_UP     = 3'd3,
      ST_SERDES_RST  = 3'd4,
      ST_FAIL        = 3'd5
   } link_state_e;

   localparam int unsigned LOCK_TIMEOUT_DEF  = 1024;
   localparam int unsigned RST_PULSE_DEF     = 4;
   localparam int unsigned HIGH_BER_HOLD_DEF = 64;
   localparam int unsigned MAX_RETRY_DEF     = 8;

endpackage

// File: rtl/eth_phy_10g_link_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// eth_sat_counter
// Up-counter that sticks at all-ones; synchronous clear has priority over
// increment.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : clear to zero
//   inc        : increment by one unless saturated
//   count      : current count
// -----------------------------------------------------------------------------
module eth_sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/eth_phy_10g_link_ctrl.sv
// -----------------------------------------------------------------------------
// eth_phy_10g_link_ctrl
// Receive-side bring-up and recovery sequencer for eth_phy_10g. Pulses the PHY
// receive reset, waits for block lock and link status, escalates to a SerDes
// receive reset on lock timeout or PHY request, and gives up in FAIL after
// MAX_RETRY SerDes resets until fail_clear.
//
// Ports:
//   rx_clk, rx_rst_n      : receive clock, asynchronous active-low reset
//   rx_block_lock         : PHY block lock
//   rx_high_ber           : PHY high BER flag
//   rx_status             : PHY link status
//   serdes_rx_reset_req   : PHY request for a SerDes reset
//   rx_bad_block          : PHY bad-block strobe
//   rx_sequence_error     : PHY sequence-error strobe
//   fail_clear            : leaves FAIL
//   phy_rx_rst            : active-high reset to eth_phy_10g rx_rst
//   serdes_rx_rst         : active-high SerDes receive reset
//   link_up               : link usable
//   link_state            : current state encoding
//   retry_count           : SerDes resets since last LINK_UP (saturating)
//   bad_block_count       : bad blocks seen in LINK_UP
//   seq_error_count       : sequence errors seen in LINK_UP
//
// Build option: define ETH_LINK_CTRL_ERR_CNT_EN to build the error counters;
// otherwise bad_block_count / seq_error_count read as zero.
// -----------------------------------------------------------------------------
module eth_phy_10g_link_ctrl
   import eth_phy_10g_pkg::*;
#(
   parameter int unsigned LOCK_TIMEOUT  = LOCK_TIMEOUT_DEF,
   parameter int unsigned RST_PULSE     = RST_PULSE_DEF,
   parameter int unsigned HIGH_BER_HOLD = HIGH_BER_HOLD_DEF,
   parameter int unsigned MAX_RETRY     = MAX_RETRY_DEF,
   parameter int unsigned CNT_WIDTH     = 16
) (
   input  logic                             rx_clk,
   input  logic                             rx_rst_n,
   input  logic                             rx_block_lock,
   input  logic                             rx_high_ber,
   input  logic                             rx_status,
   input  logic                             serdes_rx_reset_req,
   input  logic                             rx_bad_block,
   input  logic                             rx_sequence_error,
   input  logic                             fail_clear,
   output logic                             phy_rx_rst,
   output logic                             serdes_rx_rst,
   output logic                             link_up,
   output logic [STATE_W-1:0]               link_state,
   output logic [$clog2(MAX_RETRY+1)-1:0]   retry_count,
   output logic [CNT_WIDTH-1:0]             bad_block_count,
   output logic [CNT_WIDTH-1:0]             seq_error_count
);

   localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);
   localparam int unsigned TMR_MAX = (LOCK_TIMEOUT > RST_PULSE) ? LOCK_TIMEOUT : RST_PULSE;
   localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
   localparam int unsigned HOLD_W  = $clog2(HIGH_BER_HOLD + 1);

   link_state_e        state_q, state_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic [RETRY_W-1:0] retry_q, retry_d;
   logic               phy_rx_rst_q, phy_rx_rst_d;
   logic               serdes_rx_rst_q, serdes_rx_rst_d;
   logic               link_up_q, link_up_d;

   logic [HOLD_W-1:0]  ber_hold_cnt;
   logic               hold_inc;
   logic               hold_clr;
   logic               ber_trip;
   logic               entry;

   // ---------------------------------------------------------------------------
   // Next-state and registered-output decode
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      // Hold counter holds prior consecutive high samples, so this sample
      // completes the run when it reads HIGH_BER_HOLD-1.
      ber_trip = rx_high_ber && (ber_hold_cnt == HOLD_W'(HIGH_BER_HOLD - 1));

      case (state_q)
         ST_PHY_RST: begin
            if (timer_q == TMR_W'(RST_PULSE - 1)) state_d = ST_WAIT_LOCK;
         end
         ST_WAIT_LOCK: begin
            if (serdes_rx_reset_req)                          state_d = ST_SERDES_RST;
            else if (rx_block_lock)                           state_d = ST_WAIT_STATUS;
            else if (timer_q == TMR_W'(LOCK_TIMEOUT - 1))     state_d = ST_SERDES_RST;
         end
         ST_WAIT_STATUS: begin
            if (serdes_rx_reset_req)  state_d = ST_SERDES_RST;
            else if (!rx_block_lock)  state_d = ST_WAIT_LOCK;
            else if (rx_status)       state_d = ST_LINK_UP;
         end
         ST_LINK_UP: begin
            if (serdes_rx_reset_req)  state_d = ST_SERDES_RST;
            else if (!rx_block_lock)  state_d = ST_WAIT_LOCK;
            else if (ber_trip)        state_d = ST_PHY_RST;
         end
         ST_SERDES_RST: begin
            if (timer_q == TMR_W'(RST_PULSE - 1)) begin
               state_d = (retry_q >= RETRY_W'(MAX_RETRY)) ? ST_FAIL : ST_PHY_RST;
            end
         end
         ST_FAIL: begin
            if (fail_clear) state_d = ST_PHY_RST;
         end
         default: state_d = ST_PHY_RST;
      endcase

      entry = (state_d != state_q);

      timer_d = timer_q;
      if (entry) begin
         timer_d = '0;
      end else if (state_q inside {ST_PHY_RST, ST_WAIT_LOCK, ST_SERDES_RST}) begin
         timer_d = timer_q + 1'b1;
      end

      // Retry count is bumped on SerDes-reset entry, so the exit check in
      // SERDES_RST already includes the current attempt.
      retry_d = retry_q;
      if (state_q == ST_FAIL && fail_clear) begin
         retry_d = '0;
      end else if (entry && state_d == ST_LINK_UP) begin
         retry_d = '0;
      end else if (entry && state_d == ST_SERDES_RST && retry_q < RETRY_W'(MAX_RETRY)) begin
         retry_d = retry_q + 1'b1;
      end

      phy_rx_rst_d    = (state_d == ST_PHY_RST);
      serdes_rx_rst_d = (state_d == ST_SERDES_RST);
      link_up_d       = (state_d == ST_LINK_UP);

      hold_inc = (state_q == ST_LINK_UP) && rx_high_ber;
      hold_clr = entry || !hold_inc;
   end

   always_ff @(posedge rx_clk or negedge rx_rst_n) begin
      if (!rx_rst_n) begin
         state_q         <= ST_PHY_RST;
         timer_q         <= '0;
         retry_q         <= '0;
         phy_rx_rst_q    <= 1'b1;
         serdes_rx_rst_q <= 1'b0;
         link_up_q       <= 1'b0;
      end else begin
         state_q         <= state_d;
         timer_q         <= timer_d;
         retry_q         <= retry_d;
         phy_rx_rst_q    <= phy_rx_rst_d;
         serdes_rx_rst_q <= serdes_rx_rst_d;
         link_up_q       <= link_up_d;
      end
   end

   eth_sat_counter #(.WIDTH(HOLD_W)) u_ber_hold (
      .clk   (rx_clk),
      .rst_n (rx_rst_n),
      .clr   (hold_clr),
      .inc   (hold_inc),
      .count (ber_hold_cnt)
   );

   assign phy_rx_rst    = phy_rx_rst_q;
   assign serdes_rx_rst = serdes_rx_rst_q;
   assign link_up       = link_up_q;
   assign link_state    = state_q;
   assign retry_count   = retry_q;

   // ---------------------------------------------------------------------------
   // Optional error counters
   // ---------------------------------------------------------------------------
`ifdef ETH_LINK_CTRL_ERR_CNT_EN
   logic in_link_up;
   logic link_up_entry;

   assign in_link_up    = (state_q == ST_LINK_UP);
   assign link_up_entry = (state_d == ST_LINK_UP) && !in_link_up;

   eth_sat_counter #(.WIDTH(CNT_WIDTH)) u_bad_block_cnt (
      .clk   (rx_clk),
      .rst_n (rx_rst_n),
      .clr   (link_up_entry),
      .inc   (in_link_up && rx_bad_block),
      .count (bad_block_count)
   );

   eth_sat_counter #(.WIDTH(CNT_WIDTH)) u_seq_error_cnt (
      .clk   (rx_clk),
      .rst_n (rx_rst_n),
      .clr   (link_up_entry),
      .inc   (in_link_up && rx_sequence_error),
      .count (seq_error_count)
   );
`else
   logic unused_err_strobes;

   assign unused_err_strobes = rx_bad_block ^ rx_sequence_error;
   assign bad_block_count    = '0;
   assign seq_error_count    = '0;
`endif

endmodule

// File: tb/tb_eth_phy_10g_link_ctrl.sv
// -----------------------------------------------------------------------------
// tb_eth_phy_10g_link_ctrl
// Scoreboard bench for eth_phy_10g_link_ctrl: a cycle model predicts the
// outputs for the next cycle as each input vector is driven; the prediction
// is popped and compared after the clock edge. Directed checks cover the key
// timing points of bring-up, retry exhaustion, high-BER recovery, request
// priority, asynchronous reset and (with ETH_LINK_CTRL_ERR_CNT_EN) the error
// counters.
// -----------------------------------------------------------------------------
module tb_eth_phy_10g_link_ctrl;

   localparam int unsigned LOCK_TIMEOUT  = 16;
   localparam int unsigned RST_PULSE     = 4;
   localparam int unsigned HIGH_BER_HOLD = 8;
   localparam int unsigned MAX_RETRY     = 3;
   localparam int unsigned CNT_WIDTH     = 16;
   localparam int unsigned RETRY_W       = $clog2(MAX_RETRY + 1);

`ifdef ETH_LINK_CTRL_ERR_CNT_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic                 rx_clk = 1'b0;
   logic                 rx_rst_n;
   logic                 rx_block_lock;
   logic                 rx_high_ber;
   logic                 rx_status;
   logic                 serdes_rx_reset_req;
   logic                 rx_bad_block;
   logic                 rx_sequence_error;
   logic                 fail_clear;
   logic                 phy_rx_rst;
   logic                 serdes_rx_rst;
   logic                 link_up;
   logic [2:0]           link_state;
   logic [RETRY_W-1:0]   retry_count;
   logic [CNT_WIDTH-1:0] bad_block_count;
   logic [CNT_WIDTH-1:0] seq_error_count;

   always #5 rx_clk = ~rx_clk;

   eth_phy_10g_link_ctrl #(
      .LOCK_TIMEOUT  (LOCK_TIMEOUT),
      .RST_PULSE     (RST_PULSE),
      .HIGH_BER_HOLD (HIGH_BER_HOLD),
      .MAX_RETRY     (MAX_RETRY),
      .CNT_WIDTH     (CNT_WIDTH)
   ) dut (
      .rx_clk              (rx_clk),
      .rx_rst_n            (rx_rst_n),
      .rx_block_lock       (rx_block_lock),
      .rx_high_ber         (rx_high_ber),
      .rx_status           (rx_status),
      .serdes_rx_reset_req (serdes_rx_reset_req),
      .rx_bad_block        (rx_bad_block),
      .rx_sequence_error   (rx_sequence_error),
      .fail_clear          (fail_clear),
      .phy_rx_rst          (phy_rx_rst),
      .serdes_rx_rst       (serdes_rx_rst),
      .link_up             (link_up),
      .link_state          (link_state),
      .retry_count         (retry_count),
      .bad_block_count     (bad_block_count),
      .seq_error_count     (seq_error_count)
   );

   typedef struct packed {
      logic [2:0]           st;
      logic                 phy;
      logic                 serdes;
      logic                 up;
      logic [RETRY_W-1:0]   retry;
      logic [CNT_WIDTH-1:0] bb;
      logic [CNT_WIDTH-1:0] se;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Behavioural model: state number, cycles spent in the state, current run
   // of high-BER samples, retries and error tallies.
   int m_st, m_cyc, m_run, m_retry, m_bb, m_se;
   int serdes_pulses;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_cyc = 0; m_run = 0; m_retry = 0; m_bb = 0; m_se = 0;
   endtask

   task automatic model_step();
      int nxt;
      int run;
      int cnt_max;
      nxt     = m_st;
      run     = 0;
      cnt_max = (1 << CNT_WIDTH) - 1;
      case (m_st)
         0: if (m_cyc + 1 == int'(RST_PULSE)) nxt = 1;
         1: begin
            if (serdes_rx_reset_req)                      nxt = 4;
            else if (rx_block_lock)                       nxt = 2;
            else if (m_cyc + 1 == int'(LOCK_TIMEOUT))     nxt = 4;
         end
         2: begin
            if (serdes_rx_reset_req)  nxt = 4;
            else if (!rx_block_lock)  nxt = 1;
            else if (rx_status)       nxt = 3;
         end
         3: begin
            run = rx_high_ber ? m_run + 1 : 0;
            if (serdes_rx_reset_req)                  nxt = 4;
            else if (!rx_block_lock)                  nxt = 1;
            else if (run == int'(HIGH_BER_HOLD))      nxt = 0;
            if (rx_bad_block && m_bb < cnt_max)       m_bb++;
            if (rx_sequence_error && m_se < cnt_max)  m_se++;
         end
         4: if (m_cyc + 1 == int'(RST_PULSE)) nxt = (m_retry == int'(MAX_RETRY)) ? 5 : 0;
         5: if (fail_clear) nxt = 0;
         default: nxt = 0;
      endcase
      if (nxt != m_st) begin
         m_cyc = 0;
         m_run = 0;
         if (m_st == 5) m_retry = 0;
         if (nxt == 4 && m_retry < int'(MAX_RETRY)) m_retry++;
         if (nxt == 3) begin
            m_retry = 0; m_bb = 0; m_se = 0;
         end
      end else begin
         m_cyc++;
         m_run = run;
      end
      m_st = nxt;
   endtask

   // Drive the current inputs for one cycle: predict, clock, compare.
   task automatic cyc();
      exp_t e;
      exp_t got;
      model_step();
      e.st     = 3'(m_st);
      e.phy    = (m_st == 0);
      e.serdes = (m_st == 4);
      e.up     = (m_st == 3);
      e.retry  = RETRY_W'(m_retry);
      e.bb     = ERR_EN ? CNT_WIDTH'(m_bb) : '0;
      e.se     = ERR_EN ? CNT_WIDTH'(m_se) : '0;
      exp_q.push_back(e);
      @(posedge rx_clk);
      #1;
      if (serdes_rx_rst) serdes_pulses += 0;
      got = exp_q.pop_front();
      chk("sb_state",  32'(link_state),      32'(got.st));
      chk("sb_phy",    32'(phy_rx_rst),      32'(got.phy));
      chk("sb_serdes", 32'(serdes_rx_rst),   32'(got.serdes));
      chk("sb_up",     32'(link_up),         32'(got.up));
      chk("sb_retry",  32'(retry_count),     32'(got.retry));
      chk("sb_bb",     32'(bad_block_count), 32'(got.bb));
      chk("sb_se",     32'(seq_error_count), 32'(got.se));
   endtask

   task automatic do_reset();
      rx_rst_n            = 1'b0;
      rx_block_lock       = 1'b0;
      rx_high_ber         = 1'b0;
      rx_status           = 1'b0;
      serdes_rx_reset_req = 1'b0;
      rx_bad_block        = 1'b0;
      rx_sequence_error   = 1'b0;
      fail_clear          = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge rx_clk);
      #1;
      chk("rst_state",  32'(link_state),    32'd0);
      chk("rst_phy",    32'(phy_rx_rst),    32'd1);
      chk("rst_serdes", 32'(serdes_rx_rst), 32'd0);
      chk("rst_up",     32'(link_up),       32'd0);
      chk("rst_retry",  32'(retry_count),   32'd0);
      rx_rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      logic prev_serdes;

      // Bring-up: lock at cycle 10, status at cycle 12.
      do_reset();
      for (int c = 0; c < 16; c++) begin
         rx_block_lock = (c >= 10);
         rx_status     = (c >= 12);
         if (c <= 3)  chk("t1_phy_pulse", 32'(phy_rx_rst), 32'd1);
         if (c == 4)  chk("t1_phy_end",   32'(phy_rx_rst), 32'd0);
         if (c == 11) chk("t1_wait_status", 32'(link_state), 32'd2);
         if (c == 12) chk("t1_up_early",  32'(link_up), 32'd0);
         if (c == 13) begin
            chk("t1_link_up", 32'(link_up),     32'd1);
            chk("t1_retry0",  32'(retry_count), 32'd0);
         end
         cyc();
      end

      // Lock lost and never regained: three SerDes resets, then FAIL.
      rx_block_lock = 1'b0;
      rx_status     = 1'b0;
      serdes_pulses = 0;
      prev_serdes   = 1'b0;
      for (int i = 0; i < 80; i++) begin
         serdes_rx_reset_req = (i >= 75);   // ignored once in FAIL
         cyc();
         if (serdes_rx_rst && !prev_serdes) serdes_pulses++;
         prev_serdes = serdes_rx_rst;
      end
      serdes_rx_reset_req = 1'b0;
      chk("t2_pulses",     32'(serdes_pulses), 32'd3);
      chk("t2_fail_state", 32'(link_state),    32'd5);
      chk("t2_fail_retry", 32'(retry_count),   32'd3);
      chk("t2_fail_up",    32'(link_up),       32'd0);
      fail_clear = 1'b1;
      cyc();
      fail_clear = 1'b0;
      chk("t2_clear_state", 32'(link_state),  32'd0);
      chk("t2_clear_retry", 32'(retry_count), 32'd0);

      rx_block_lock = 1'b1;
      rx_status     = 1'b1;
      repeat (8) cyc();
      chk("t3_up", 32'(link_up), 32'd1);

      // High BER: 7 high, 1 low, then 8 high.
      rx_high_ber = 1'b1;
      repeat (7) cyc();
      rx_high_ber = 1'b0;
      cyc();
      chk("t3_burst1_no_rst", 32'(phy_rx_rst), 32'd0);
      rx_high_ber = 1'b1;
      repeat (7) cyc();
      chk("t3_burst2_7th", 32'(phy_rx_rst), 32'd0);
      cyc();
      chk("t3_burst2_8th", 32'(phy_rx_rst), 32'd1);
      chk("t3_state_phy",  32'(link_state), 32'd0);
      rx_high_ber = 1'b0;
      repeat (8) cyc();
      chk("t4_up", 32'(link_up), 32'd1);

      // Reset request beats lock loss in the same cycle.
      serdes_rx_reset_req = 1'b1;
      rx_block_lock       = 1'b0;
      cyc();
      serdes_rx_reset_req = 1'b0;
      chk("t4_req_prio", 32'(link_state),  32'd4);
      chk("t4_retry1",   32'(retry_count), 32'd1);
      cyc();

      // Asynchronous reset in the middle of the SerDes pulse.
      #3;
      rx_rst_n = 1'b0;
      #1;
      chk("t5_async_serdes", 32'(serdes_rx_rst), 32'd0);
      chk("t5_async_phy",    32'(phy_rx_rst),    32'd1);
      chk("t5_async_state",  32'(link_state),    32'd0);

      // Error counters: 5 bad blocks / 2 seq errors in LINK_UP, more outside.
      do_reset();
      rx_block_lock = 1'b1;
      rx_status     = 1'b1;
      repeat (8) cyc();
      for (int i = 0; i < 10; i++) begin
         rx_bad_block      = (i % 2 == 0);
         rx_sequence_error = (i == 1 || i == 5);
         cyc();
      end
      rx_bad_block      = 1'b0;
      rx_sequence_error = 1'b0;
      rx_block_lock     = 1'b0;
      cyc();
      for (int i = 0; i < 6; i++) begin
         rx_bad_block      = (i % 2 == 0);
         rx_sequence_error = (i == 1);
         cyc();
      end
      rx_bad_block      = 1'b0;
      rx_sequence_error = 1'b0;
      chk("t6_bad_block", 32'(bad_block_count), ERR_EN ? 32'd5 : 32'd0);
      chk("t6_seq_error", 32'(seq_error_count), ERR_EN ? 32'd2 : 32'd0);
      chk("t6_sb_empty",  32'(exp_q.size()),    32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/eth_phy_10g_link_ctrl.md
Name: eth_phy_10g_link_ctrl

Overview:
- Receive-side bring-up and recovery sequencer for eth_phy_10g.
- Watches PHY status (rx_block_lock, rx_high_ber, rx_status, serdes_rx_reset_req).
- Drives the PHY receive reset and a SerDes receive reset, retries with a bounded count, and reports a registered link_up.
- Replaces manual pulsing of rx_rst in benches and top levels to clear high_ber.

Parameters:
- LOCK_TIMEOUT, 1024: cycles allowed in WAIT_LOCK before a SerDes reset.
- RST_PULSE, 4: width in cycles of phy_rx_rst and serdes_rx_rst pulses.
- HIGH_BER_HOLD, 64: consecutive cycles of rx_high_ber in LINK_UP before a PHY reset.
- MAX_RETRY, 8: SerDes resets allowed before FAIL.
- CNT_WIDTH, 16: width of the error counters.

Ports:
- rx_clk  in  1  receive clock, same domain as eth_phy_10g rx_clk.
- rx_rst_n  in  1  reset; asynchronous assert, active-low.
- rx_block_lock  in  1  PHY block lock.
- rx_high_ber  in  1  PHY high BER flag.
- rx_status  in  1  PHY link status.
- serdes_rx_reset_req  in  1  PHY request for a SerDes reset.
- rx_bad_block  in  1  PHY bad-block strobe.
- rx_sequence_error  in  1  PHY sequence-error strobe.
- fail_clear  in  1  single-cycle strobe; leaves FAIL.
- phy_rx_rst  out  1  active-high reset to eth_phy_10g rx_rst.
- serdes_rx_rst  out  1  active-high SerDes receive reset.
- link_up  out  1  link usable.
- link_state  out  3  current state encoding.
- retry_count  out  $clog2(MAX_RETRY+1)  SerDes resets since last LINK_UP.
- bad_block_count  out  CNT_WIDTH  see Optional Feature.
- seq_error_count  out  CNT_WIDTH  see Optional Feature.

Behaviour:
- Reset (rx_rst_n low, async):
  - state = PHY_RST; all counters = 0.
  - phy_rx_rst = 1; serdes_rx_rst = 0; link_up = 0.
- Outputs are registered and decoded from next-state, so each changes on the same edge as link_state.
- PHY_RST:
  - phy_rx_rst = 1 for exactly RST_PULSE cycles, counted from reset release or from entry.
  - Then go to WAIT_LOCK.
- WAIT_LOCK:
  - Timer increments each cycle.
  - rx_block_lock = 1 -> WAIT_STATUS.
  - Timer reaching LOCK_TIMEOUT-1 without lock -> SERDES_RST.
- WAIT_STATUS:
  - rx_status = 1 -> LINK_UP; on that edge link_up = 1 and retry_count clears to 0.
  - rx_block_lock = 0 -> WAIT_LOCK.
- LINK_UP:
  - rx_block_lock = 0 -> WAIT_LOCK.
  - rx_high_ber high for HIGH_BER_HOLD consecutive samples -> PHY_RST. Any low sample clears the hold counter.
- SERDES_RST:
  - serdes_rx_rst = 1 for RST_PULSE cycles; retry_count increments on entry.
  - On pulse end: retry_count == MAX_RETRY -> FAIL, otherwise -> PHY_RST.
- FAIL:
  - All reset outputs 0; link_up = 0.
  - fail_clear -> PHY_RST with retry_count = 0.
  - All other inputs are ignored.
- serdes_rx_reset_req:
  - In WAIT_LOCK, WAIT_STATUS or LINK_UP, it goes to SERDES_RST and overrides every other transition that cycle.
  - Ignored in PHY_RST, SERDES_RST and FAIL.
- Priority in LINK_UP: serdes_rx_reset_req > lock loss > high BER.
- Each state entry clears the timer and the hold counter.
- retry_count saturates at MAX_RETRY.
- State encoding: PHY_RST=0, WAIT_LOCK=1, WAIT_STATUS=2, LINK_UP=3, SERDES_RST=4, FAIL=5.

Optional Feature:
- Macro ETH_LINK_CTRL_ERR_CNT_EN.
- Defined:
  - bad_block_count and seq_error_count count their strobes only while in LINK_UP.
  - Both saturate at all-ones and clear to 0 on entry to LINK_UP.
- Undefined: both outputs are tied to 0 and no counter registers are built.

Decomposition:
- Package eth_phy_10g_pkg holds:
  - the state localparams and the 3-bit state width;
  - default constants for LOCK_TIMEOUT, RST_PULSE, HIGH_BER_HOLD and MAX_RETRY.
- One sub-module, eth_sat_counter: parameterised width, with increment, clear and saturate.
  - Used for the error counters and the high-BER hold counter.

Test Plan (LOCK_TIMEOUT=16, RST_PULSE=4, HIGH_BER_HOLD=8, MAX_RETRY=3):
- Release rx_rst_n; raise lock at cycle 10 and status at cycle 12 -> phy_rx_rst high for cycles 0-3; link_state=2 at cycle 11; link_up=1 from cycle 13; retry_count=0.
- Lock held low -> serdes_rx_rst pulses 4 cycles after each 16-cycle wait. After the 3rd pulse, link_state=5, retry_count=3, link_up=0. fail_clear -> link_state=0, retry_count=0.
- In LINK_UP: high_ber 7 cycles, one low cycle, then 8 cycles -> no reset after the first burst; phy_rx_rst rises on the 8th consecutive sample of the second burst.
- In LINK_UP: assert serdes_rx_reset_req and drop lock in the same cycle -> link_state=4 (not 1); retry_count=1.
- rx_rst_n pulsed low mid-SERDES_RST -> serdes_rx_rst=0 and phy_rx_rst=1 immediately (async), with no clock edge needed.
- With ETH_LINK_CTRL_ERR_CNT_EN: 5 rx_bad_block strobes in LINK_UP and 3 in WAIT_LOCK -> bad_block_count=5. Without the macro it reads 0.
